// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divider issue controller
//
// Purpose: default operand width, default watchdog limit, FSM state encoding
//          and the divide-by-zero quotient constant.
// Ports:   none (package).

package div_pkg;

    localparam int DIV_N_WIDTH     = 32;
    localparam int DIV_TIMEOUT_CYC = 48;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DIVZ  = 3'd4,
        ST_DRAIN = 3'd5
    } div_state_e;

    // LO written for a zero divisor (quotient saturates to all ones).
    localparam logic [DIV_N_WIDTH-1:0] DIVZ_LO = '1;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - start/operand and done/result link to the iterative divider
//
// Purpose: bundles the controller <-> divider handshake.
// Ports (signals):
//   divstart   ctrl->div  one-cycle start
//   divsigned  ctrl->div  1 = signed divide
//   dividend   ctrl->div  dividend, held while the divide runs
//   divisor    ctrl->div  divisor, held while the divide runs
//   quotient   div->ctrl  quotient, valid with done_vld
//   remainder  div->ctrl  remainder, valid with done_vld
//   done_vld   div->ctrl  one-cycle completion pulse
//   ready      div->ctrl  divider idle, will accept a start
// Modports: master = controller, slave = divider.

interface div_issue_ctrl_if #(
    parameter int N_WIDTH = div_pkg::DIV_N_WIDTH
);

    logic               divstart;
    logic               divsigned;
    logic [N_WIDTH-1:0] dividend;
    logic [N_WIDTH-1:0] divisor;
    logic [N_WIDTH-1:0] quotient;
    logic [N_WIDTH-1:0] remainder;
    logic               done_vld;
    logic               ready;

    modport master (
        output divstart, divsigned, dividend, divisor,
        input  quotient, remainder, done_vld, ready
    );

    modport slave (
        input  divstart, divsigned, dividend, divisor,
        output quotient, remainder, done_vld, ready
    );

endinterface

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage issue/retire controller for the iterative divider
//
// Purpose: latches a DIV/DIVU request, issues a one-cycle start when the
//          divider is ready, stalls the pipeline until the result returns and
//          writes HI (remainder) / LO (quotient). Handles divide-by-zero
//          locally, flush of an in-flight divide and a watchdog timeout.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_ex_div     EX holds a valid DIV/DIVU
//   i_ex_signed  1 = DIV, 0 = DIVU
//   i_op_a       dividend
//   i_op_b       divisor
//   i_flush      annul the in-flight instruction
//   o_stall_req  hold IF/ID/EX
//   o_hilo_we    one-cycle HI/LO write strobe
//   o_hi         remainder, valid with o_hilo_we
//   o_lo         quotient, valid with o_hilo_we
//   o_timeout    one-cycle watchdog pulse
//   div_bus      master side of the divider link

module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int N_WIDTH     = DIV_N_WIDTH,
    parameter int TIMEOUT_CYC = DIV_TIMEOUT_CYC
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ex_div,
    input  logic                i_ex_signed,
    input  logic [N_WIDTH-1:0]  i_op_a,
    input  logic [N_WIDTH-1:0]  i_op_b,
    input  logic                i_flush,
    output logic                o_stall_req,
    output logic                o_hilo_we,
    output logic [N_WIDTH-1:0]  o_hi,
    output logic [N_WIDTH-1:0]  o_lo,
    output logic                o_timeout,
    div_issue_ctrl_if.master    div_bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    div_state_e         state_q;
    logic [N_WIDTH-1:0] dividend_q;
    logic [N_WIDTH-1:0] divisor_q;
    logic               signed_q;
    logic [N_WIDTH-1:0] res_hi_q;
    logic [N_WIDTH-1:0] res_lo_q;
    logic [CNT_W-1:0]   wd_cnt_q;

    logic req_take;
    logic wd_expired;

    assign req_take   = i_ex_div && !i_flush;
    assign wd_expired = (wd_cnt_q == CNT_LAST);

    // Operands come straight from the latched registers so they stay
    // stable for the whole ISSUE/WAIT window.
    assign div_bus.dividend  = dividend_q;
    assign div_bus.divisor   = divisor_q;
    assign div_bus.divsigned = signed_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            wd_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_take) begin
                        dividend_q <= i_op_a;
                        divisor_q  <= i_op_b;
                        signed_q   <= i_ex_signed;
                        if (i_op_b == '0) begin
                            res_lo_q <= N_WIDTH'(DIVZ_LO);
                            res_hi_q <= i_op_a;
                            state_q  <= ST_DIVZ;
                        end else begin
                            state_q  <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (i_flush) begin
                        state_q <= ST_IDLE;
                    end else if (div_bus.ready) begin
                        wd_cnt_q <= '0;
                        state_q  <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (i_flush) begin
                        // A done arriving with the flush is already consumed,
                        // so there is nothing left to drain.
                        state_q  <= div_bus.done_vld ? ST_IDLE : ST_DRAIN;
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end else if (div_bus.done_vld) begin
                        res_hi_q <= div_bus.remainder;
                        res_lo_q <= div_bus.quotient;
                        state_q  <= ST_DONE;
                    end else if (wd_expired) begin
                        state_q  <= ST_IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end

                ST_DONE, ST_DIVZ: begin
                    state_q <= ST_IDLE;
                end

                ST_DRAIN: begin
                    // The watchdog keeps running so a dead divider cannot
                    // park the controller here; the annulled op reports nothing.
                    if (div_bus.done_vld || wd_expired) begin
                        state_q <= ST_IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_stall_req      = 1'b0;
        o_hilo_we        = 1'b0;
        o_timeout        = 1'b0;
        div_bus.divstart = 1'b0;
        case (state_q)
            ST_IDLE:  o_stall_req = req_take;
            ST_ISSUE: begin
                o_stall_req      = !i_flush;
                div_bus.divstart = div_bus.ready && !i_flush;
            end
            ST_WAIT: begin
                o_stall_req = !i_flush;
                o_timeout   = wd_expired && !i_flush && !div_bus.done_vld;
            end
            ST_DONE, ST_DIVZ: o_hilo_we   = !i_flush;
            // A younger request arriving while the old result drains waits
            // here and is latched once IDLE is reached.
            ST_DRAIN:         o_stall_req = req_take;
            default:          o_stall_req = 1'b0;
        endcase
    end

    assign o_hi = o_hilo_we ? res_hi_q : '0;
    assign o_lo = o_hilo_we ? res_lo_q : '0;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl with a divider model

module tb_div_issue_ctrl;
    import div_pkg::*;

    localparam int W   = 32;
    localparam int TO  = 48;
    localparam int LAT = 6;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_ex_div;
    logic         i_ex_signed;
    logic [W-1:0] i_op_a;
    logic [W-1:0] i_op_b;
    logic         i_flush;
    logic         o_stall_req;
    logic         o_hilo_we;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;
    logic         o_timeout;

    int nvec  = 0;
    int nfail = 0;

    always #5 i_clk = ~i_clk;

    div_issue_ctrl_if #(.N_WIDTH(W)) dbus ();

    div_issue_ctrl #(.N_WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ex_div    (i_ex_div),
        .i_ex_signed (i_ex_signed),
        .i_op_a      (i_op_a),
        .i_op_b      (i_op_b),
        .i_flush     (i_flush),
        .o_stall_req (o_stall_req),
        .o_hilo_we   (o_hilo_we),
        .o_hi        (o_hi),
        .o_lo        (o_lo),
        .o_timeout   (o_timeout),
        .div_bus     (dbus)
    );

    // Iterative divider model: fixed latency, optional stuck-busy mode.
    logic         ready_en   = 1'b1;
    logic         never_done = 1'b0;
    logic         m_busy     = 1'b0;
    logic         m_done     = 1'b0;
    int           m_lcnt     = 0;
    logic [W-1:0] m_q        = '0;
    logic [W-1:0] m_r        = '0;

    assign dbus.ready     = ready_en && !m_busy;
    assign dbus.done_vld  = m_done;
    assign dbus.quotient  = m_q;
    assign dbus.remainder = m_r;

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_lcnt <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy && !never_done) begin
                if (m_lcnt <= 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_lcnt <= m_lcnt - 1;
                end
            end
            if (dbus.divstart && dbus.ready) begin
                m_busy <= 1'b1;
                m_lcnt <= LAT;
                if (dbus.divsigned) begin
                    m_q <= $signed(dbus.dividend) / $signed(dbus.divisor);
                    m_r <= $signed(dbus.dividend) % $signed(dbus.divisor);
                end else begin
                    m_q <= dbus.dividend / dbus.divisor;
                    m_r <= dbus.dividend % dbus.divisor;
                end
            end
        end
    end

    // Presents one request and holds it until the HI/LO write (or max_cyc).
    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input int max_cyc,
                          output int n_start, output int start_cyc,
                          output int n_stall, output int n_we, output int we_cyc,
                          output logic [W-1:0] lo, output logic [W-1:0] hi);
        n_start = 0; start_cyc = -1; n_stall = 0; n_we = 0; we_cyc = -1;
        lo = '0; hi = '0;
        i_op_a = a; i_op_b = b; i_ex_signed = sgn; i_ex_div = 1'b1;
        for (int c = 0; c < max_cyc && n_we == 0; c++) begin
            @(negedge i_clk);
            if (o_divstart_s()) begin
                n_start++;
                if (start_cyc < 0) start_cyc = c;
            end
            if (o_stall_req) n_stall++;
            if (o_hilo_we) begin
                n_we++; we_cyc = c; lo = o_lo; hi = o_hi;
            end
            @(posedge i_clk); #1;
        end
        i_ex_div = 1'b0;
    endtask

    function automatic logic o_divstart_s();
        return dbus.divstart;
    endfunction

    task automatic test_reset();
        i_rst = 1'b1; i_ex_div = 1'b0; i_ex_signed = 1'b0;
        i_op_a = '0; i_op_b = '0; i_flush = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        nvec++;
        if ({o_stall_req, o_hilo_we, o_timeout, dbus.divstart, dbus.divsigned} !== 5'b0) begin
            nfail++;
            $display("FAIL reset_ctl: got %b expected 00000",
                     {o_stall_req, o_hilo_we, o_timeout, dbus.divstart, dbus.divsigned});
        end
        nvec++;
        if ({dbus.dividend, dbus.divisor, o_hi, o_lo} !== 128'b0) begin
            nfail++;
            $display("FAIL reset_data: got %h expected 0", {dbus.dividend, dbus.divisor, o_hi, o_lo});
        end
        nvec++;
        if (dut.state_q !== ST_IDLE) begin
            nfail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_signed();
        int ns, sc, nst, nw, wc; logic [W-1:0] lo, hi;
        do_req(32'hFFFF_FFFA, 32'd5, 1'b1, 30, ns, sc, nst, nw, wc, lo, hi);
        nvec++; if (ns !== 1) begin nfail++; $display("FAIL signed_starts: got %0d expected 1", ns); end
        nvec++; if (sc !== 1) begin nfail++; $display("FAIL signed_start_cyc: got %0d expected 1", sc); end
        nvec++; if (nw !== 1) begin nfail++; $display("FAIL signed_we: got %0d expected 1", nw); end
        nvec++; if (nst !== wc) begin nfail++; $display("FAIL signed_stall: got %0d expected %0d", nst, wc); end
        nvec++; if (lo !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL signed_lo: got %h expected ffffffff", lo); end
        nvec++; if (hi !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL signed_hi: got %h expected ffffffff", hi); end
        @(negedge i_clk);
        nvec++; if ({o_stall_req, o_hilo_we} !== 2'b00) begin
            nfail++; $display("FAIL signed_after: got %b expected 00", {o_stall_req, o_hilo_we});
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_unsigned();
        int ns, sc, nst, nw, wc; logic [W-1:0] lo, hi;
        do_req(32'hFFFF_FFFA, 32'd5, 1'b0, 30, ns, sc, nst, nw, wc, lo, hi);
        nvec++; if (ns !== 1) begin nfail++; $display("FAIL unsigned_starts: got %0d expected 1", ns); end
        nvec++; if (nw !== 1) begin nfail++; $display("FAIL unsigned_we: got %0d expected 1", nw); end
        nvec++; if (lo !== 32'h3333_3332) begin nfail++; $display("FAIL unsigned_lo: got %h expected 33333332", lo); end
        nvec++; if (hi !== 32'h0) begin nfail++; $display("FAIL unsigned_hi: got %h expected 0", hi); end
    endtask

    task automatic test_divzero();
        int ns, sc, nst, nw, wc; logic [W-1:0] lo, hi;
        do_req(32'd100, 32'd0, 1'b1, 10, ns, sc, nst, nw, wc, lo, hi);
        nvec++; if (ns !== 0) begin nfail++; $display("FAIL divz_starts: got %0d expected 0", ns); end
        nvec++; if (wc !== 1) begin nfail++; $display("FAIL divz_we_cyc: got %0d expected 1", wc); end
        nvec++; if (nst !== 1) begin nfail++; $display("FAIL divz_stall: got %0d expected 1", nst); end
        nvec++; if (lo !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL divz_lo: got %h expected ffffffff", lo); end
        nvec++; if (hi !== 32'd100) begin nfail++; $display("FAIL divz_hi: got %h expected 64", hi); end
    endtask

    task automatic test_ready_low();
        int ns, sc, nst, nw, wc, early; logic [W-1:0] lo, hi;
        early = 0;
        ready_en = 1'b0;
        i_op_a = 32'd1000; i_op_b = 32'd7; i_ex_signed = 1'b0; i_ex_div = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            if (dbus.divstart) early++;
            @(posedge i_clk); #1;
        end
        nvec++; if (early !== 0) begin nfail++; $display("FAIL rdy_no_start: got %0d expected 0", early); end
        nvec++; if (dut.state_q !== ST_ISSUE) begin
            nfail++; $display("FAIL rdy_state: got %0d expected %0d", dut.state_q, ST_ISSUE);
        end
        nvec++; if ({dbus.dividend, dbus.divisor} !== {32'd1000, 32'd7}) begin
            nfail++; $display("FAIL rdy_operands: got %h expected %h", {dbus.dividend, dbus.divisor}, {32'd1000, 32'd7});
        end
        ready_en = 1'b1;
        do_req(32'd1000, 32'd7, 1'b0, 30, ns, sc, nst, nw, wc, lo, hi);
        nvec++; if (sc !== 0) begin nfail++; $display("FAIL rdy_start_cyc: got %0d expected 0", sc); end
        nvec++; if (ns !== 1) begin nfail++; $display("FAIL rdy_starts: got %0d expected 1", ns); end
        nvec++; if ({lo, hi} !== {32'd142, 32'd6}) begin
            nfail++; $display("FAIL rdy_result: got %h expected %h", {lo, hi}, {32'd142, 32'd6});
        end
    endtask

    task automatic test_flush();
        int ns, sc, nst, nw, wc, s, n_we0; logic [W-1:0] lo, hi;
        logic flushed;
        s = -1; n_we0 = 0; flushed = 1'b0;
        i_op_a = 32'd7; i_op_b = 32'd2; i_ex_signed = 1'b0; i_ex_div = 1'b1;
        for (int c = 0; c < 20 && !flushed; c++) begin
            if (s >= 0 && c == s + 3) begin
                i_flush = 1'b1; i_ex_div = 1'b0;
            end
            @(negedge i_clk);
            if (o_hilo_we) n_we0++;
            if (i_flush) begin
                flushed = 1'b1;
                nvec++; if (o_stall_req !== 1'b0) begin
                    nfail++; $display("FAIL flush_stall_drop: got %b expected 0", o_stall_req);
                end
            end
            if (dbus.divstart && s < 0) s = c;
            @(posedge i_clk); #1;
        end
        i_flush = 1'b0;
        nvec++; if (!flushed) begin nfail++; $display("FAIL flush_reached: got 0 expected 1"); end
        nvec++; if (dut.state_q !== ST_DRAIN) begin
            nfail++; $display("FAIL flush_state: got %0d expected %0d", dut.state_q, ST_DRAIN);
        end
        @(negedge i_clk);
        if (o_hilo_we) n_we0++;
        nvec++; if (o_stall_req !== 1'b0) begin
            nfail++; $display("FAIL drain_stall: got %b expected 0", o_stall_req);
        end
        @(posedge i_clk); #1;
        do_req(32'd9, 32'd3, 1'b0, 40, ns, sc, nst, nw, wc, lo, hi);
        nvec++; if (n_we0 !== 0) begin nfail++; $display("FAIL flush_no_we: got %0d expected 0", n_we0); end
        nvec++; if (nw !== 1) begin nfail++; $display("FAIL flush_next_we: got %0d expected 1", nw); end
        nvec++; if (nst !== wc) begin nfail++; $display("FAIL flush_next_stall: got %0d expected %0d", nst, wc); end
        nvec++; if ({lo, hi} !== {32'd3, 32'd0}) begin
            nfail++; $display("FAIL flush_next_result: got %h expected %h", {lo, hi}, {32'd3, 32'd0});
        end
    endtask

    task automatic test_timeout();
        int s, t, n_tmo, n_we, n_stall, n_we2;
        s = -1; t = -1; n_tmo = 0; n_we = 0; n_stall = 0; n_we2 = 0;
        never_done = 1'b1;
        i_op_a = 32'd50; i_op_b = 32'd5; i_ex_signed = 1'b0; i_ex_div = 1'b1;
        for (int c = 0; c < 80 && t < 0; c++) begin
            @(negedge i_clk);
            if (dbus.divstart && s < 0) s = c;
            if (o_stall_req) n_stall++;
            if (o_hilo_we) n_we++;
            if (o_timeout) begin n_tmo++; t = c; end
            @(posedge i_clk); #1;
        end
        i_ex_div = 1'b0;
        nvec++; if (n_tmo !== 1) begin nfail++; $display("FAIL tmo_pulse: got %0d expected 1", n_tmo); end
        nvec++; if (t - s !== TO) begin nfail++; $display("FAIL tmo_delay: got %0d expected %0d", t - s, TO); end
        nvec++; if (n_stall !== t + 1) begin nfail++; $display("FAIL tmo_stall: got %0d expected %0d", n_stall, t + 1); end
        nvec++; if (dut.state_q !== ST_IDLE) begin
            nfail++; $display("FAIL tmo_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        // Let the model's late done arrive while the controller is idle.
        never_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (o_hilo_we || o_timeout || o_stall_req) n_we2++;
            @(posedge i_clk); #1;
        end
        nvec++; if (n_we + n_we2 !== 0) begin
            nfail++; $display("FAIL tmo_quiet: got %0d expected 0", n_we + n_we2);
        end
    endtask

    task automatic test_reset_mid();
        int ns, sc, nst, nw, wc, s; logic [W-1:0] lo, hi;
        s = -1;
        i_op_a = 32'd40; i_op_b = 32'd8; i_ex_signed = 1'b1; i_ex_div = 1'b1;
        for (int c = 0; c < 10 && !(s >= 0 && c == s + 3); c++) begin
            @(negedge i_clk);
            if (dbus.divstart && s < 0) s = c;
            @(posedge i_clk); #1;
        end
        nvec++; if (dut.state_q !== ST_WAIT) begin
            nfail++; $display("FAIL rstmid_pre_state: got %0d expected %0d", dut.state_q, ST_WAIT);
        end
        i_rst = 1'b1; i_ex_div = 1'b0;
        @(posedge i_clk); #1;
        nvec++;
        if ({o_stall_req, o_hilo_we, o_timeout, dbus.divstart, dbus.divsigned,
             dbus.dividend, dbus.divisor, o_hi, o_lo} !== 133'b0) begin
            nfail++; $display("FAIL rstmid_outputs: got %h expected 0",
                {o_stall_req, o_hilo_we, o_timeout, dbus.divstart, dbus.divsigned,
                 dbus.dividend, dbus.divisor, o_hi, o_lo});
        end
        nvec++; if (dut.state_q !== ST_IDLE) begin
            nfail++; $display("FAIL rstmid_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        do_req(32'd6, 32'd3, 1'b0, 30, ns, sc, nst, nw, wc, lo, hi);
        nvec++; if (nw !== 1) begin nfail++; $display("FAIL rstmid_we: got %0d expected 1", nw); end
        nvec++; if ({lo, hi} !== {32'd2, 32'd0}) begin
            nfail++; $display("FAIL rstmid_result: got %h expected %h", {lo, hi}, {32'd2, 32'd0});
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_divzero();
        test_ready_low();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

endmodule
